// File: rtl/pixel_plot_sink_pkg.sv
// Shared widths, screen geometry, FSM encoding and the FIFO entry layout for the pixel sink.
package pixel_plot_sink_pkg;
  localparam int H_RES      = 320;
  localparam int V_RES      = 240;
  localparam int COLOUR_W   = 15;
  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int FB_ADDR_W  = 17;
  localparam int FIFO_DEPTH = 4;
  localparam int FB_PIXELS  = H_RES * V_RES;
  localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = FB_ADDR_W'(FB_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_CLEAR} state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*320 + x built from shifts so no multiplier is needed
  function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input logic [X_W-1:0] x,
                                                       input logic [Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] yy;
    yy = FB_ADDR_W'(y);
    return (yy << 8) + (yy << 6) + FB_ADDR_W'(x);
  endfunction
endpackage

// File: rtl/pixel_plot_sink_if.sv
// Pixel plot stream from the loader mux: valid/ready handshake carrying one (x, y, colour) per transfer.
interface pixel_plot_sink_if;
  import pixel_plot_sink_pkg::*;
  logic                in_valid;
  logic                in_ready;
  logic [X_W-1:0]      in_x;
  logic [Y_W-1:0]      in_y;
  logic [COLOUR_W-1:0] in_colour;

  modport master (output in_valid, in_x, in_y, in_colour, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_colour, output in_ready);
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO, head visible combinationally on data_o; caller never pushes when full
// nor pops when empty.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/pixel_plot_sink.sv
// Clips incoming plots, buffers them and writes one framebuffer word per cycle (1 cycle accept->write);
// in_ready drops when the FIFO is full or a clear is draining/running.
module pixel_plot_sink
  import pixel_plot_sink_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_plot_sink_if.slave     pix,
  input  logic                 clear_req_i,
  input  logic [COLOUR_W-1:0]  clear_colour_i,
  output logic                 busy_o,
  output logic                 clear_done_o,
  output logic [7:0]           drop_count_o,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic [COLOUR_W-1:0]  fb_data_o,
  output logic                 fb_wren_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state_q, state_d;
  logic                 alive_q;
  logic                 accept, in_screen, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  pixel_t               in_pix, head;
  logic [7:0]           drop_q, drop_d;
  logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [COLOUR_W-1:0]  clr_colour_q, clr_colour_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]  fb_data_q, fb_data_d;
  logic                 fb_wren_q, fb_wren_d;
  logic                 clr_last_q, clr_last_d;
  logic                 clear_done_q, clear_done_d;

  assign in_pix    = '{x: pix.in_x, y: pix.in_y, colour: pix.in_colour};
  assign in_screen = (pix.in_x < X_W'(H_RES)) && (pix.in_y < Y_W'(V_RES));
  assign accept    = pix.in_valid && pix.in_ready;
  assign push      = accept && in_screen;

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pixel_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_pix),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (clear_req_i) state_d = ST_DRAIN;
                 else if (accept) state_d = ST_STREAM;
      ST_STREAM: if (clear_req_i) state_d = ST_DRAIN;
                 else if (fifo_empty && !accept) state_d = ST_IDLE;
      ST_DRAIN:  if (fifo_empty) state_d = ST_CLEAR;
      ST_CLEAR:  if (clr_addr_q == FB_LAST_ADDR) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // alive_q keeps in_ready low while reset is held and for the first edge after release
  always_comb begin
    pix.in_ready = alive_q && !fifo_full && (state_q == ST_IDLE || state_q == ST_STREAM);
    pop          = !fifo_empty && (state_q != ST_CLEAR);
    busy_o       = (fifo_count != '0) || (state_q == ST_DRAIN) || (state_q == ST_CLEAR);
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_screen && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    clr_addr_d   = clr_addr_q;
    clr_colour_d = clr_colour_q;
    if (state_q == ST_DRAIN && fifo_empty) begin
      clr_addr_d   = '0;
      clr_colour_d = clear_colour_i;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + FB_ADDR_W'(1);
    end

    fb_wren_d = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (pop) begin
      fb_wren_d = 1'b1;
      fb_addr_d = fb_addr_of(head.x, head.y);
      fb_data_d = head.colour;
    end else if (state_q == ST_CLEAR) begin
      fb_wren_d = 1'b1;
      fb_addr_d = clr_addr_q;
      fb_data_d = clr_colour_q;
    end

    // done pulses the cycle after the final clear write is presented
    clr_last_d   = (state_q == ST_CLEAR) && (clr_addr_q == FB_LAST_ADDR);
    clear_done_d = clr_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      drop_q       <= '0;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_wren_q    <= 1'b0;
      clr_last_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      alive_q      <= 1'b1;
      drop_q       <= drop_d;
      clr_addr_q   <= clr_addr_d;
      clr_colour_q <= clr_colour_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_wren_q    <= fb_wren_d;
      clr_last_q   <= clr_last_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign drop_count_o = drop_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_data_o    = fb_data_q;
  assign fb_wren_o    = fb_wren_q;
  assign clear_done_o = clear_done_q;
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Bench for pixel_plot_sink: directed scenarios plus random plots, scored against a queue of expected writes.
module tb_pixel_plot_sink;
  import pixel_plot_sink_pkg::*;

  localparam int LAST = 320 * 240 - 1;

  typedef struct packed {
    logic [16:0] addr;
    logic [14:0] data;
    logic        is_clear;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req;
  logic [14:0] clear_colour;
  logic        busy, clear_done, fb_wren;
  logic [7:0]  drop_count;
  logic [16:0] fb_addr;
  logic [14:0] fb_data;

  pixel_plot_sink_if pif();

  pixel_plot_sink dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix            (pif.slave),
    .clear_req_i    (clear_req),
    .clear_colour_i (clear_colour),
    .busy_o         (busy),
    .clear_done_o   (clear_done),
    .drop_count_o   (drop_count),
    .fb_addr_o      (fb_addr),
    .fb_data_o      (fb_data),
    .fb_wren_o      (fb_wren)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  passed = 0, total = 0;
  int  cyc = 0, run_len = 0, last_wr_cyc = -10, last_addr = -1;
  int  clear_left = 0, drops_model = 0, rdy_viol = 0, done_seen = 0;
  bit  done_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // One clock: at the falling edge, score any framebuffer write and the clear_done pulse.
  task automatic tick();
    wr_t e;
    bit  dn;
    @(negedge clk);
    cyc++;
    dn = 1'b0;
    if (fb_wren) begin
      if (exp_q.size() == 0) chk("spurious_wr", fb_wren, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", fb_addr, e.addr);
        chk("wr_data", fb_data, e.data);
        if (e.is_clear) begin
          clear_left--;
          dn = (int'(e.addr) == LAST);
        end
      end
      run_len     = (last_wr_cyc == cyc - 1) ? run_len + 1 : 1;
      last_wr_cyc = cyc;
      last_addr   = int'(fb_addr);
    end
    if (clear_done) done_seen++;
    if (clear_done || done_exp) chk("clear_done", clear_done, done_exp);
    done_exp = dn;
  endtask

  // Present inputs for the coming edge and record what the model expects from the handshake.
  task automatic drive(input bit v, input int x, input int y, input logic [14:0] c,
                       input bit clr, output bit acc);
    pif.in_valid  = v;
    pif.in_x      = x[8:0];
    pif.in_y      = y[7:0];
    pif.in_colour = c;
    clear_req     = clr;
    if (clear_left > 0 && pif.in_ready) rdy_viol++;
    acc = v && pif.in_ready;
    if (acc) begin
      if (x < 320 && y < 240) exp_q.push_back('{17'(y * 320 + x), c, 1'b0});
      else if (drops_model < 255) drops_model++;
    end
    if (clr) begin
      for (int a = 0; a <= LAST; a++) exp_q.push_back('{17'(a), clear_colour, 1'b1});
      clear_left = LAST + 1;
    end
  endtask

  task automatic send(input int x, input int y, input logic [14:0] c, input bit clr);
    bit acc;
    int guard = 0;
    do begin
      tick();
      drive(1'b1, x, y, c, clr, acc);
      guard++;
    end while (!acc && guard < 100);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle_until_empty(input int bound);
    bit acc;
    int n = 0;
    while ((exp_q.size() != 0 || done_exp) && n < bound) begin
      tick();
      drive(1'b0, 0, 0, 15'h0, 1'b0, acc);
      n++;
    end
    if (n >= bound) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) begin
      tick();
      drive(1'b0, 0, 0, 15'h0, 1'b0, acc);
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int stalls, n, x, y;
    pif.in_valid = 1'b0; pif.in_x = '0; pif.in_y = '0; pif.in_colour = '0;
    clear_req = 1'b0; clear_colour = '0;

    #2;
    chk("rst_ready", pif.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_wren", fb_wren, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", pif.in_ready, 1);

    // single pixel latency
    tick();
    drive(1'b1, 25, 25, 15'h7FFF, 1'b0, acc);
    tick();
    drive(1'b0, 0, 0, 15'h0, 1'b0, acc);
    chk("lat_not_early", fb_wren, 0);
    tick();
    chk("lat_wren", fb_wren, 1);
    chk("lat_addr", fb_addr, 8025);
    chk("lat_data", fb_data, 15'h7FFF);
    idle_until_empty(50);

    // 33x16 block, valid held high
    stalls = 0;
    for (int yy = 25; yy <= 40; yy++)
      for (int xx = 25; xx <= 57; xx++) begin
        n = 0;
        do begin
          tick();
          drive(1'b1, xx, yy, 15'($urandom), 1'b0, acc);
          if (!acc) stalls++;
          n++;
        end while (!acc && n < 100);
      end
    idle_until_empty(100);
    chk("blk_stalls", stalls, 0);
    chk("blk_run", run_len, 528);
    chk("blk_last", last_addr, 12857);

    // clipping and drop counter saturation
    send(320, 10, 15'h1234, 1'b0);
    send(5, 240, 15'h4321, 1'b0);
    idle_until_empty(20);
    chk("drop_two", drop_count, 2);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) send(int'($urandom_range(511, 320)), int'($urandom_range(255, 0)), 15'($urandom), 1'b0);
      else            send(int'($urandom_range(319, 0)), int'($urandom_range(255, 240)), 15'($urandom), 1'b0);
    end
    idle_until_empty(20);
    chk("drop_sat", drop_count, 255);
    chk("drop_model", drop_count, drops_model);
    chk("idle_busy", busy, 0);

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      tick();
      x = int'($urandom_range(340, 0));
      y = int'($urandom_range(250, 0));
      drive(($urandom % 4) != 0, x, y, 15'($urandom), 1'b0, acc);
    end
    idle_until_empty(50);
    chk("rand_drop", drop_count, drops_model);

    // clear with pixels queued, then a pixel held against a stalled sink
    clear_colour = 15'h0;
    rdy_viol = 0;
    done_seen = 0;
    send(1, 2, 15'h0111, 1'b0);
    send(3, 4, 15'h0222, 1'b0);
    send(5, 6, 15'h0333, 1'b1);
    tick();
    drive(1'b1, 100, 100, 15'h2AAA, 1'b0, acc);
    chk("clr_busy", busy, 1);
    n = 0;
    while (!acc && n < 80000) begin
      tick();
      drive(1'b1, 100, 100, 15'h2AAA, 1'b0, acc);
      n++;
    end
    if (!acc) chk("held_timeout", 0, 1);
    idle_until_empty(100);
    chk("clr_rdy_low", rdy_viol, 0);
    chk("clr_done_once", done_seen, 1);
    chk("clr_ready_after", pif.in_ready, 1);

    // reset in the middle of a clear
    clear_colour = 15'($urandom);
    tick();
    drive(1'b0, 0, 0, 15'h0, 1'b1, acc);
    n = 0;
    while (!(fb_wren && fb_addr == 17'd1000) && n < 5000) begin
      tick();
      drive(1'b0, 0, 0, 15'h0, 1'b0, acc);
      n++;
    end
    chk("mid_clear_reached", fb_addr, 1000);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    clear_left = 0;
    done_exp = 1'b0;
    chk("mrst_wren", fb_wren, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_data", fb_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", pif.in_ready, 0);
    drops_model = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_ready_after", pif.in_ready, 1);
    chk("mrst_drop", drop_count, 0);
    repeat (5) tick();
    send(319, 239, 15'h5555, 1'b0);
    idle_until_empty(20);
    chk("final_last", last_addr, LAST);
    chk("final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
